// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core: three debounced push-buttons drive a start/stop/lap/clear
// FSM; a prescaled tick advances a synchronous six-digit BCD count that is
// presented on a registered display word (frozen while in LAP).
// preload_en/preload_bcd load the count directly; tie both low in normal use.
module stopwatch_bcd_core #(
    parameter int CLK_IN_HZ       = 50000000,
    parameter int TICK_HZ         = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_start_n,
    input  logic        btn_lap_n,
    input  logic        btn_clear_n,
    input  logic        preload_en,
    input  logic [23:0] preload_bcd,
    output logic [23:0] bcd_out,
    output logic        running,
    output logic        lap_hold,
    output logic        overflow
);
    // DIV must be at least 2 for the prescaler to produce a distinct tick cycle.
    localparam int DIV = CLK_IN_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_LAP} state_t;

    // Button bit order: [0] start, [1] lap, [2] clear; levels are active-low.
    logic [2:0]          sync1_q, sync1_d;
    logic [2:0]          sync2_q, sync2_d;
    logic [2:0]          db_q, db_d;
    logic [2:0][DBW-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]          press;

    state_t              state_q, state_d;
    logic                presc_clr, cnt_clr;
    logic                counting, tick, carry;
    logic [PW-1:0]       presc_q, presc_d;
    logic [23:0]         cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic [23:0]         bcd_q, bcd_d;

    // Synchronize pins, debounce, and pulse on an accepted released->pressed change.
    always_comb begin
        sync1_d  = {btn_clear_n, btn_lap_n, btn_start_n};
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        press    = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_MAX) begin
                db_d[i]     = sync2_q[i];
                db_cnt_d[i] = '0;
                press[i]    = ~sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Next state; start outranks lap, lap outranks clear.
    always_comb begin
        state_d   = state_q;
        presc_clr = 1'b0;
        cnt_clr   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    state_d   = S_RUN;
                    presc_clr = 1'b1;
                end
            end
            S_RUN: begin
                if (press[0])      state_d = S_PAUSED;
                else if (press[1]) state_d = S_LAP;
            end
            S_LAP: begin
                if (press[0])      state_d = S_PAUSED;
                else if (press[1]) state_d = S_RUN;
            end
            S_PAUSED: begin
                if (press[0]) begin
                    state_d = S_RUN;
                end else if (press[2]) begin
                    state_d = S_IDLE;
                    cnt_clr = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign counting = (state_q == S_RUN) || (state_q == S_LAP);

    // Prescaler, BCD carry chain, sticky overflow and display load.
    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        carry   = 1'b0;
        tick    = counting && (presc_q == PRESC_MAX);
        if (cnt_clr) begin
            presc_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (presc_clr)     presc_d = '0;
            else if (counting) presc_d = tick ? '0 : presc_q + 1'b1;
            if (preload_en) begin
                cnt_d = preload_bcd;
            end else if (tick) begin
                carry = 1'b1;
                // A digit at 9 (or any stray value above) rolls to 0 and passes the carry on.
                for (int unsigned k = 0; k < 6; k++) begin
                    if (carry) begin
                        if (cnt_q[4*k +: 4] >= 4'd9) begin
                            cnt_d[4*k +: 4] = 4'd0;
                        end else begin
                            cnt_d[4*k +: 4] = cnt_q[4*k +: 4] + 4'd1;
                            carry           = 1'b0;
                        end
                    end
                end
                if (carry) ovf_d = 1'b1;
            end
        end
        bcd_d = (state_q == S_LAP) ? bcd_q : cnt_q;
    end

    // All state registers; buttons reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            db_q     <= '1;
            db_cnt_q <= '0;
            state_q  <= S_IDLE;
            presc_q  <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            bcd_q    <= bcd_d;
        end
    end

    assign running  = counting;
    assign lap_hold = (state_q == S_LAP);
    assign overflow = ovf_q;
    assign bcd_out  = bcd_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Self-checking bench for stopwatch_bcd_core with DIV=10, DEBOUNCE_CYCLES=4.
// Timed expectations are queued against a cycle number and compared at that negedge.
module tb_stopwatch_bcd_core;
    localparam int DIV = 10;

    logic        clk;
    logic        rst_n;
    logic        btn_start_n, btn_lap_n, btn_clear_n;
    logic        preload_en;
    logic [23:0] preload_bcd;
    logic [23:0] bcd_out;
    logic        running, lap_hold, overflow;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int base_cnt = 0;
    int vstart   = 0;

    typedef struct {
        int          due;
        logic [23:0] bcd;
        logic        run;
        logic        ovf;
    } sb_t;
    sb_t   sb_q[$];
    string sb_nm[$];

    stopwatch_bcd_core #(
        .CLK_IN_HZ(100),
        .TICK_HZ(10),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_start_n(btn_start_n),
        .btn_lap_n(btn_lap_n),
        .btn_clear_n(btn_clear_n),
        .preload_en(preload_en),
        .preload_bcd(preload_bcd),
        .bcd_out(bcd_out),
        .running(running),
        .lap_hold(lap_hold),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          x;
        r = '0;
        x = v % 1000000;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Count held by the counter after edge c, for an uninterrupted run since vstart.
    function automatic int exp_cnt(input int c);
        return (base_cnt + (c - vstart) / DIV) % 1000000;
    endfunction

    // Display lags the counter by one edge.
    function automatic logic [23:0] exp_bcd(input int c);
        return to_bcd(exp_cnt(c - 1));
    endfunction

    task automatic sb_push(input int due, input logic [23:0] bcd, input logic run,
                           input logic ovf, input string nm);
        sb_t e;
        e.due = due; e.bcd = bcd; e.run = run; e.ovf = ovf;
        sb_q.push_back(e);
        sb_nm.push_back(nm);
    endtask

    // Scoreboard consumer: compares each queued expectation at its cycle.
    initial forever begin
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            n_checks++;
            if (sb_q[0].due != cyc)
                $display("FAIL %s: expectation for cycle %0d reached at cycle %0d",
                         sb_nm[0], sb_q[0].due, cyc);
            else if (bcd_out !== sb_q[0].bcd || running !== sb_q[0].run || overflow !== sb_q[0].ovf)
                $display("FAIL %s @%0d: bcd_out=%h running=%b overflow=%b, required bcd_out=%h running=%b overflow=%b",
                         sb_nm[0], cyc, bcd_out, running, overflow, sb_q[0].bcd, sb_q[0].run, sb_q[0].ovf);
            else
                n_pass++;
            void'(sb_q.pop_front());
            void'(sb_nm.pop_front());
        end
    end

    task automatic wait_out(input int sel, input logic lvl, output int t, output bit ok);
        logic v;
        ok = 1'b0;
        t  = -1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            v = (sel == 0) ? running : (sel == 1) ? lap_hold : overflow;
            if (v === lvl) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
    endtask

    task automatic hold_release();
        repeat (5) @(negedge clk);
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        btn_clear_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            $display("FAIL sb_drain: %0d expectations still pending, required 0", sb_q.size());
            sb_q.delete();
            sb_nm.delete();
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bcd_out !== 24'h0) $display("FAIL reset_bcd: bcd_out=%h required 000000", bcd_out);
        else n_pass++;
        n_checks++;
        if (running !== 1'b0) $display("FAIL reset_running: running=%b required 0", running);
        else n_pass++;
        n_checks++;
        if (lap_hold !== 1'b0) $display("FAIL reset_lap_hold: lap_hold=%b required 0", lap_hold);
        else n_pass++;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL reset_overflow: overflow=%b required 0", overflow);
        else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_bounce();
        logic saw;
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            btn_start_n = ((i / 2) % 2) != 0;
            @(negedge clk);
            saw = saw | running | lap_hold;
        end
        btn_start_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            saw = saw | running | lap_hold;
        end
        n_checks++;
        if (saw !== 1'b0) $display("FAIL bounce_ignored: state left IDLE (saw=%b), required 0", saw);
        else n_pass++;
        n_checks++;
        if (bcd_out !== 24'h0) $display("FAIL bounce_count: bcd_out=%h required 000000", bcd_out);
        else n_pass++;
    endtask

    task automatic test_start();
        int t;
        bit ok;
        btn_start_n = 1'b0;
        wait_out(0, 1'b1, t, ok);
        n_checks++;
        if (!ok) $display("FAIL start_press: running=%b required 1 within 40 cycles", running);
        else n_pass++;
        if (ok) begin
            base_cnt = 0;
            vstart   = t;
            sb_push(t + 9,   exp_bcd(t + 9),  1'b1, 1'b0, "first_tick_before");
            sb_push(t + 10,  exp_bcd(t + 10), 1'b1, 1'b0, "first_tick_lag");
            sb_push(t + 11,  24'h000001,      1'b1, 1'b0, "first_tick");
            sb_push(t + 125, 24'h000012,      1'b1, 1'b0, "run_125");
        end
        hold_release();
        wait_drain();
    endtask

    task automatic test_lap();
        int t;
        bit ok;
        btn_start_n = 1'b0;
        wait_out(0, 1'b0, t, ok);
        hold_release();
        btn_clear_n = 1'b0;
        repeat (8) @(negedge clk);
        hold_release();
        btn_start_n = 1'b0;
        wait_out(0, 1'b1, t, ok);
        n_checks++;
        if (!ok) $display("FAIL lap_restart: running=%b required 1 within 40 cycles", running);
        else n_pass++;
        base_cnt = 0;
        vstart   = t;
        hold_release();
        ok = 1'b0;
        for (int i = 0; i < 120 && !ok; i++) begin
            @(negedge clk);
            if (bcd_out === 24'h000005) ok = 1'b1;
        end
        n_checks++;
        if (!ok) $display("FAIL lap_reach5: bcd_out=%h required 000005 within 120 cycles", bcd_out);
        else n_pass++;
        btn_lap_n = 1'b0;
        wait_out(1, 1'b1, t, ok);
        n_checks++;
        if (!ok || bcd_out !== 24'h000005)
            $display("FAIL lap_enter: lap_hold=%b bcd_out=%h, required 1 and 000005", lap_hold, bcd_out);
        else n_pass++;
        hold_release();
        for (int k = 0; k < 4; k++) begin
            repeat (10) @(negedge clk);
            n_checks++;
            if (bcd_out !== 24'h000005 || lap_hold !== 1'b1 || running !== 1'b1)
                $display("FAIL lap_frozen_%0d: bcd_out=%h lap_hold=%b running=%b, required 000005 1 1",
                         k, bcd_out, lap_hold, running);
            else n_pass++;
        end
        btn_lap_n = 1'b0;
        wait_out(1, 1'b0, t, ok);
        n_checks++;
        if (!ok) $display("FAIL lap_exit: lap_hold=%b required 0 within 40 cycles", lap_hold);
        else n_pass++;
        if (ok) begin
            sb_push(t + 1,  exp_bcd(t + 1),  1'b1, 1'b0, "lap_live");
            sb_push(t + 12, exp_bcd(t + 12), 1'b1, 1'b0, "lap_live_later");
        end
        hold_release();
        wait_drain();
    endtask

    task automatic test_pause_resume();
        int t, held, c0;
        bit ok;
        for (int i = 0; i < 10 && ((cyc - vstart) % DIV) != 0; i++) @(negedge clk);
        btn_start_n = 1'b0;
        wait_out(0, 1'b0, t, ok);
        n_checks++;
        if (!ok) $display("FAIL pause_entry: running=%b required 0 within 40 cycles", running);
        else n_pass++;
        held = (t - vstart) % DIV;
        c0   = exp_cnt(t);
        hold_release();
        n_checks++;
        if (bcd_out !== to_bcd(c0)) $display("FAIL paused_value: bcd_out=%h required %h", bcd_out, to_bcd(c0));
        else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++;
        if (bcd_out !== to_bcd(c0)) $display("FAIL paused_hold: bcd_out=%h required %h", bcd_out, to_bcd(c0));
        else n_pass++;
        btn_start_n = 1'b0;
        wait_out(0, 1'b1, t, ok);
        n_checks++;
        if (!ok) $display("FAIL resume_entry: running=%b required 1 within 40 cycles", running);
        else n_pass++;
        if (ok) begin
            base_cnt = c0;
            vstart   = t - held;
            sb_push(t + DIV - held,         to_bcd(c0),     1'b1, 1'b0, "resume_before_tick");
            sb_push(t + DIV + 1 - held,     to_bcd(c0 + 1), 1'b1, 1'b0, "resume_tick");
            sb_push(t + 2 * DIV + 1 - held, to_bcd(c0 + 2), 1'b1, 1'b0, "resume_second_tick");
        end
        hold_release();
        wait_drain();
    endtask

    task automatic test_overflow();
        int t, held, c;
        bit ok;
        btn_start_n = 1'b0;
        wait_out(0, 1'b0, t, ok);
        held = (t - vstart) % DIV;
        hold_release();
        preload_en  = 1'b1;
        preload_bcd = 24'h999998;
        sb_push(cyc + 2, 24'h999998, 1'b0, 1'b0, "preload");
        @(negedge clk);
        preload_en = 1'b0;
        repeat (3) @(negedge clk);
        btn_start_n = 1'b0;
        wait_out(0, 1'b1, t, ok);
        n_checks++;
        if (!ok) $display("FAIL ovf_run: running=%b required 1 within 40 cycles", running);
        else n_pass++;
        if (ok) begin
            base_cnt = 999998;
            vstart   = t - held;
            c = t + 2 * DIV - held;
            sb_push(c - 1,   exp_bcd(c - 1),   1'b1, 1'b0, "before_wrap");
            sb_push(c,       exp_bcd(c),       1'b1, 1'b1, "overflow_rise");
            sb_push(c + 1,   24'h000000,       1'b1, 1'b1, "wrap_display");
            sb_push(c + 11,  exp_bcd(c + 11),  1'b1, 1'b1, "after_wrap");
        end
        hold_release();
        wait_drain();
        btn_start_n = 1'b0;
        wait_out(0, 1'b0, t, ok);
        hold_release();
        btn_clear_n = 1'b0;
        wait_out(2, 1'b0, t, ok);
        n_checks++;
        if (!ok) $display("FAIL clear_overflow: overflow=%b required 0 within 40 cycles", overflow);
        else n_pass++;
        if (ok) sb_push(t + 1, 24'h000000, 1'b0, 1'b0, "clear_zero");
        hold_release();
        wait_drain();
    endtask

    task automatic test_simultaneous();
        int t, held, c0;
        bit ok;
        btn_start_n = 1'b0;
        wait_out(0, 1'b1, t, ok);
        n_checks++;
        if (!ok) $display("FAIL idle_start: running=%b required 1 within 40 cycles", running);
        else n_pass++;
        if (ok) begin
            base_cnt = 0;
            vstart   = t;
            sb_push(t + 10, 24'h000000, 1'b1, 1'b0, "idle_restart_lag");
            sb_push(t + 11, 24'h000001, 1'b1, 1'b0, "idle_restart_tick");
        end
        hold_release();
        repeat (20) @(negedge clk);
        wait_drain();
        btn_start_n = 1'b0;
        wait_out(0, 1'b0, t, ok);
        held = (t - vstart) % DIV;
        c0   = exp_cnt(t);
        hold_release();
        btn_start_n = 1'b0;
        btn_clear_n = 1'b0;
        wait_out(0, 1'b1, t, ok);
        n_checks++;
        if (!ok) $display("FAIL simul_start: running=%b required 1 within 40 cycles", running);
        else n_pass++;
        if (ok) begin
            base_cnt = c0;
            vstart   = t - held;
            sb_push(t + 1,              to_bcd(c0),     1'b1, 1'b0, "simul_keep");
            sb_push(t + DIV + 1 - held, to_bcd(c0 + 1), 1'b1, 1'b0, "simul_tick");
        end
        hold_release();
        wait_drain();
    endtask

    task automatic test_reset_midrun();
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bcd_out !== 24'h0) $display("FAIL async_rst_bcd: bcd_out=%h required 000000", bcd_out);
        else n_pass++;
        n_checks++;
        if (running !== 1'b0 || lap_hold !== 1'b0 || overflow !== 1'b0)
            $display("FAIL async_rst_flags: running=%b lap_hold=%b overflow=%b, required 0 0 0",
                     running, lap_hold, overflow);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        n_checks++;
        if (bcd_out !== 24'h0 || running !== 1'b0)
            $display("FAIL rst_no_tick: bcd_out=%h running=%b, required 000000 0", bcd_out, running);
        else n_pass++;
    endtask

    initial begin
        rst_n       = 1'b0;
        btn_start_n = 1'b1;
        btn_lap_n   = 1'b1;
        btn_clear_n = 1'b1;
        preload_en  = 1'b0;
        preload_bcd = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_bounce();
        test_start();
        test_lap();
        test_pause_resume();
        test_overflow();
        test_simultaneous();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded 50000 cycles, required completion");
        $fatal(1);
    end

endmodule
